// File: rtl/clint_mh_pkg.sv
// Shared constants and helpers for the multi-hart CLINT.
// Offsets are relative to the decoded 64 KiB region.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_mh_if.sv
// Data-memory bus port of the CLINT.
// rdata and addr_valid are combinational on the slave side.
interface clint_bus_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        read_en;
  logic [31:0] rdata;
  logic        addr_valid;

  modport master (
    output addr, wdata, wstrb, read_en,
    input  rdata, addr_valid
  );

  modport slave (
    input  addr, wdata, wstrb, read_en,
    output rdata, addr_valid
  );

endinterface

// File: rtl/clint_mh_hart_slot.sv
// Per-hart state: mtimecmp, msip, comparator and IRQ flops.
// IRQs are registered from current register values.
module clint_hart_slot
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic        msip_we_i,
  output logic [63:0] mtimecmp_o,
  output logic        msip_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o
);

  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic        tirq_q, sirq_q;

  always_comb begin
    cmp_d  = cmp_q;
    msip_d = msip_q;
    if (cmp_lo_we_i)
      cmp_d[31:0] = byte_merge(cmp_q[31:0], wdata_i, wstrb_i);
    if (cmp_hi_we_i)
      cmp_d[63:32] = byte_merge(cmp_q[63:32], wdata_i, wstrb_i);
    if (msip_we_i && wstrb_i[0])
      msip_d = wdata_i[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q  <= MTIMECMP_RESET;
      msip_q <= 1'b0;
      tirq_q <= 1'b0;
      sirq_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      msip_q <= msip_d;
      tirq_q <= (mtime_i >= cmp_q);
      sirq_q <= msip_q;
    end
  end

  assign mtimecmp_o  = cmp_q;
  assign msip_o      = msip_q;
  assign timer_irq_o = tirq_q;
  assign soft_irq_o  = sirq_q;

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart slots,
// address decode and combinational read mux.
module clint_mh
  import clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  clint_bus_if.slave           bus,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq,
  output logic [63:0]          mtime_out
);

  localparam logic [15:0] PRE_MAX  = 16'(TICK_DIV - 1);
  localparam logic [16:0] MSIP_LEN = 17'(4 * NUM_HARTS);
  localparam logic [16:0] CMP_LEN  = 17'(8 * NUM_HARTS);

  logic [15:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  logic [15:0] off;
  logic        hit, we;
  logic [16:0] msip_rel, cmp_rel;
  logic        msip_sel, cmp_sel, lo_sel, hi_sel;
  logic [2:0]  msip_idx, cmp_idx;
  logic        cmp_hi;

  logic [63:0]          cmp_v [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_v;
  logic [63:0]          cmp_rd;
  logic                 msip_rd;
  logic [31:0]          rdata_d;

  assign off = bus.addr[15:0];
  assign hit = (bus.addr[31:16] == BASE_ADDR[31:16])
            && (bus.addr[1:0] == 2'b00);
  assign we  = |bus.wstrb;

  // Offsets below a range wrap to >= 2^16, so one compare bounds both ends.
  assign msip_rel = {1'b0, off} - {1'b0, MSIP_OFF};
  assign cmp_rel  = {1'b0, off} - {1'b0, MTIMECMP_OFF};

  assign msip_sel = hit && (msip_rel < MSIP_LEN);
  assign cmp_sel  = hit && (cmp_rel < CMP_LEN);
  assign lo_sel   = hit && (off == MTIME_LO_OFF);
  assign hi_sel   = hit && (off == MTIME_HI_OFF);

  assign msip_idx = msip_rel[4:2];
  assign cmp_idx  = cmp_rel[5:3];
  assign cmp_hi   = cmp_rel[2];

  assign bus.addr_valid = msip_sel | cmp_sel | lo_sel | hi_sel;

  assign tick  = (pre_q == PRE_MAX);
  assign pre_d = tick ? 16'd0 : pre_q + 16'd1;

  always_comb begin
    mtime_d = mtime_q;
    if (we && lo_sel)
      mtime_d[31:0] = byte_merge(mtime_q[31:0], bus.wdata, bus.wstrb);
    else if (we && hi_sel)
      mtime_d[63:32] = byte_merge(mtime_q[63:32], bus.wdata, bus.wstrb);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      mtime_q <= '0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    clint_hart_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .mtime_i     (mtime_q),
      .wdata_i     (bus.wdata),
      .wstrb_i     (bus.wstrb),
      .cmp_lo_we_i (we && cmp_sel && !cmp_hi && cmp_idx == 3'(h)),
      .cmp_hi_we_i (we && cmp_sel && cmp_hi && cmp_idx == 3'(h)),
      .msip_we_i   (we && msip_sel && msip_idx == 3'(h)),
      .mtimecmp_o  (cmp_v[h]),
      .msip_o      (msip_v[h]),
      .timer_irq_o (timer_irq[h]),
      .soft_irq_o  (soft_irq[h])
    );
  end

  always_comb begin
    msip_rd = 1'b0;
    cmp_rd  = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (msip_idx == 3'(i)) msip_rd = msip_v[i];
      if (cmp_idx == 3'(i))  cmp_rd  = cmp_v[i];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (bus.read_en) begin
      unique case (1'b1)
        lo_sel:   rdata_d = mtime_q[31:0];
        hi_sel:   rdata_d = mtime_q[63:32];
        msip_sel: rdata_d = {31'b0, msip_rd};
        cmp_sel:  rdata_d = cmp_hi ? cmp_rd[63:32] : cmp_rd[31:0];
        default:  rdata_d = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_d;
  assign mtime_out = mtime_q;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: two instances (TICK_DIV 1 and 4) share one
// stimulus stream and are checked against a register-level model.
module tb_clint_mh;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_addr  = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_ren   = 1'b0;

  clint_bus_if bus_a ();
  clint_bus_if bus_b ();

  assign bus_a.addr    = s_addr;
  assign bus_a.wdata   = s_wdata;
  assign bus_a.wstrb   = s_wstrb;
  assign bus_a.read_en = s_ren;
  assign bus_b.addr    = s_addr;
  assign bus_b.wdata   = s_wdata;
  assign bus_b.wstrb   = s_wstrb;
  assign bus_b.read_en = s_ren;

  logic [1:0]  tirq_a, sirq_a, tirq_b, sirq_b;
  logic [63:0] mt_a, mt_b;

  clint_mh #(
    .NUM_HARTS(2), .BASE_ADDR(32'h0200_0000), .TICK_DIV(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .timer_irq(tirq_a), .soft_irq(sirq_a), .mtime_out(mt_a)
  );

  clint_mh #(
    .NUM_HARTS(2), .BASE_ADDR(32'h0200_0000), .TICK_DIV(4)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .timer_irq(tirq_b), .soft_irq(sirq_b), .mtime_out(mt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model state, index [dut][hart]
  longint unsigned m_mt  [2];
  longint unsigned m_cmp [2][2];
  bit              m_msip[2][2];
  bit              m_t   [2][2];
  bit              m_s   [2][2];
  int              m_cyc [2];

  function automatic longint unsigned merge32(
    input longint unsigned old, input int sh,
    input logic [31:0] d, input logic [3:0] s);
    longint unsigned mask;
    mask = 0;
    for (int b = 0; b < 4; b++)
      if (s[b]) mask |= 64'hFF << (sh + 8 * b);
    return (old & ~mask) | (({32'b0, d} << sh) & mask);
  endfunction

  // kind: 0 none, 1 msip, 2 mtimecmp, 3 mtime
  task automatic decode(input logic [31:0] a, output int kind,
                        output int h, output bit hi);
    int off;
    kind = 0; h = 0; hi = 0;
    if (a[31:16] == 16'h0200 && a % 4 == 0) begin
      off = int'(a & 32'hFFFF);
      if (off < 8) begin
        kind = 1; h = off / 4;
      end else if (off >= 'h4000 && off < 'h4010) begin
        kind = 2; h = (off - 'h4000) / 8; hi = (off % 8) == 4;
      end else if (off == 'hBFF8) begin
        kind = 3;
      end else if (off == 'hBFFC) begin
        kind = 3; hi = 1;
      end
    end
  endtask

  task automatic exp_bus(input int k, output bit v,
                         output logic [31:0] d);
    int kind, h; bit hi;
    decode(s_addr, kind, h, hi);
    v = kind != 0;
    d = '0;
    if (v && s_ren) begin
      case (kind)
        1: d = {31'b0, m_msip[k][h]};
        2: d = 32'(m_cmp[k][h] >> (hi ? 32 : 0));
        default: d = 32'(m_mt[k] >> (hi ? 32 : 0));
      endcase
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mt[k] = 0; m_cyc[k] = 0;
      for (int h = 0; h < 2; h++) begin
        m_cmp[k][h] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[k][h] = 0; m_t[k][h] = 0; m_s[k][h] = 0;
      end
    end
  endtask

  task automatic model_step();
    int kind, h, div; bit hi, tk, mw;
    decode(s_addr, kind, h, hi);
    for (int k = 0; k < 2; k++) begin
      div = (k == 0) ? 1 : 4;
      for (int j = 0; j < 2; j++) begin
        m_t[k][j] = m_mt[k] >= m_cmp[k][j];
        m_s[k][j] = m_msip[k][j];
      end
      tk = (m_cyc[k] % div) == div - 1;
      m_cyc[k]++;
      mw = 0;
      if (s_wstrb != 0) begin
        case (kind)
          1: if (s_wstrb[0]) m_msip[k][h] = s_wdata[0];
          2: m_cmp[k][h] = merge32(m_cmp[k][h], hi ? 32 : 0, s_wdata, s_wstrb);
          3: begin
            m_mt[k] = merge32(m_mt[k], hi ? 32 : 0, s_wdata, s_wstrb);
            mw = 1;
          end
          default: ;
        endcase
      end
      if (!mw && tk) m_mt[k]++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    bit v; logic [31:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("mtime_a", mt_a, m_mt[0]);
        chk("mtime_b", mt_b, m_mt[1]);
        chk("tirq_a", tirq_a, {m_t[0][1], m_t[0][0]});
        chk("tirq_b", tirq_b, {m_t[1][1], m_t[1][0]});
        chk("sirq_a", sirq_a, {m_s[0][1], m_s[0][0]});
        chk("sirq_b", sirq_b, {m_s[1][1], m_s[1][0]});
        exp_bus(0, v, d);
        chk("valid_a", bus_a.addr_valid, v);
        chk("rdata_a", bus_a.rdata, d);
        exp_bus(1, v, d);
        chk("valid_b", bus_b.addr_valid, v);
        chk("rdata_b", bus_b.rdata, d);
      end
    end
  end

  task automatic idle();
    s_addr = '0; s_wdata = '0; s_wstrb = '0; s_ren = 1'b0;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    s_addr = a; s_wdata = d; s_wstrb = s; s_ren = 1'b0;
    cyc();
    idle();
  endtask

  initial begin
    logic [31:0] v1, v2;
    bit found;

    repeat (2) @(negedge clk);
    chk("rst_mtime", mt_a, 64'd0);
    chk("rst_tirq", tirq_a, 2'b00);
    chk("rst_sirq", sirq_a, 2'b00);
    chk("rst_valid", bus_a.addr_valid, 1'b0);
    chk("rst_rdata", bus_a.rdata, 32'd0);
    #2 rst = 1'b0;
    s_addr = 32'h0200_BFF8; s_ren = 1'b1;

    @(negedge clk);
    v1 = bus_a.rdata;
    chk("mt_first", v1, 32'd1);
    chk("b_mt0", mt_b, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b_mt0_late", mt_b, 64'd0);
    @(negedge clk);
    v2 = bus_a.rdata;
    chk("mt_delta3", v2 - v1, 32'd3);
    chk("b_tick4", mt_b, 64'd1);
    cyc();
    s_addr = 32'h0200_4000;
    @(negedge clk);
    chk("cmp0_lo_rst", bus_a.rdata, 32'hFFFF_FFFF);
    chk("tirq_idle", tirq_a, 2'b00);
    cyc();
    idle();

    wr(32'h0200_BFF8, 32'd0, 4'hF);
    wr(32'h0200_400C, 32'd0, 4'hF);
    wr(32'h0200_4008, 32'd20, 4'hF);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mt_a == 64'd20) begin found = 1; break; end
    end
    chk("reach20", found, 1'b1);
    chk("t1_at20", tirq_a, 2'b00);
    @(negedge clk);
    chk("t1_rise", tirq_a, 2'b10);
    cyc();
    wr(32'h0200_4008, 32'd1000, 4'hF);
    @(negedge clk);
    chk("t1_hold", tirq_a, 2'b10);
    @(negedge clk);
    chk("t1_clear", tirq_a, 2'b00);

    cyc();
    wr(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0200_BFFC, 32'd0, 4'hF);
    @(negedge clk);
    chk("wrap_pre", mt_a, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("wrap_a", mt_a, 64'h0000_0001_0000_0000);
    for (int i = 0; i < 10; i++) begin
      if (mt_b != 64'h0000_0000_FFFF_FFFF) break;
      @(negedge clk);
    end
    chk("wrap_b", mt_b, 64'h0000_0001_0000_0000);

    cyc();
    wr(32'h0200_0004, 32'd1, 4'b0001);
    @(negedge clk);
    chk("msip_lag", sirq_a, 2'b00);
    @(negedge clk);
    chk("msip_set", sirq_a, 2'b10);
    cyc();
    wr(32'h0200_0004, 32'd0, 4'b0010);
    s_addr = 32'h0200_0004; s_ren = 1'b1;
    @(negedge clk);
    chk("msip_keep", sirq_a, 2'b10);
    chk("msip_rd", bus_a.rdata, 32'd1);
    cyc();
    idle();

    wr(32'h0200_BFFC, 32'd5, 4'hF);
    wr(32'h0200_BFF8, 32'hAABB_CCDD, 4'hF);
    wr(32'h0200_BFF8, 32'h0000_1234, 4'b0011);
    @(negedge clk);
    chk("tickwr", mt_a, 64'h0000_0005_AABB_1234);
    @(negedge clk);
    chk("tickwr_inc", mt_a, 64'h0000_0005_AABB_1235);

    cyc();
    s_addr = 32'h0200_4008; s_wdata = 32'd7;
    s_wstrb = 4'hF; s_ren = 1'b1;
    @(negedge clk);
    chk("rw_old", bus_a.rdata, 32'd1000);
    cyc();
    idle();

    s_addr = 32'h0200_4010; s_wdata = 32'd0;
    s_wstrb = 4'hF; s_ren = 1'b1;
    @(negedge clk);
    chk("inv_valid", bus_a.addr_valid, 1'b0);
    chk("inv_rdata", bus_a.rdata, 32'd0);
    cyc();
    idle();
    s_addr = 32'h0200_4000; s_ren = 1'b1;
    @(negedge clk);
    chk("inv_nochg", bus_a.rdata, 32'hFFFF_FFFF);
    cyc();
    idle();

    @(negedge clk);
    chk("pre_rst_t", tirq_a, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_t", tirq_a, 2'b00);
    chk("rst_async_s", sirq_a, 2'b00);
    chk("rst_async_mt", mt_a, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(6);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
